// File: rtl/motor_pkg.sv
// Shared definitions for the motor command ramp block.
// Holds default parameter values, direction encodings and the per-channel
// slew state type used by motor_ramp_ch and motor_cmd_ramp.
package motor_pkg;

    localparam int PERIOD_DEF  = 11000;
    localparam int SPEED_W_DEF = 14;
    localparam int STEP_DEF    = 250;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        HOLD,
        RAMP_UP,
        RAMP_DN,
        REVERSE
    } ch_state_e;

endpackage

// File: rtl/motor_ramp_ch.sv
// One motor channel: target registers, slew FSM and saturating arithmetic.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   tick_i           last cycle of a PWM period; applied outputs move here
//   load_i           accept ld_speed_i/ld_dir_i as the new target
//   estop_i          level emergency stop: speed and target forced to 0
//   ld_speed_i/dir_i target speed (clamped to PERIOD) and direction
//   speed_o/dir_o    applied speed and direction
//   active_o         channel not in HOLD
module motor_ramp_ch
    import motor_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int SPEED_W = SPEED_W_DEF,
    parameter int STEP    = STEP_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               load_i,
    input  logic               estop_i,
    input  logic [SPEED_W-1:0] ld_speed_i,
    input  logic               ld_dir_i,
    output logic [SPEED_W-1:0] speed_o,
    output logic               dir_o,
    output logic               active_o
);

    localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(PERIOD);
    localparam logic [SPEED_W-1:0] STEP_V  = SPEED_W'(STEP);

    ch_state_e          state_q, state_d;
    logic [SPEED_W-1:0] cur_q, cur_d;
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] tgt_q, tgt_d;
    logic               tdir_q, tdir_d;
    logic [SPEED_W:0]   up_sum;
    logic [SPEED_W-1:0] dn_dif;

    function automatic ch_state_e classify(
        input logic [SPEED_W-1:0] c,
        input logic               d,
        input logic [SPEED_W-1:0] t,
        input logic               td
    );
        if (d != td)    return REVERSE;
        else if (c < t) return RAMP_UP;
        else if (c > t) return RAMP_DN;
        else            return HOLD;
    endfunction

    // State is re-derived every cycle from the post-update registers, so a
    // load (or a target reverted mid-reversal) is reflected by the next tick.
    always_comb begin
        cur_d   = cur_q;
        dir_d   = dir_q;
        tgt_d   = tgt_q;
        tdir_d  = tdir_q;
        up_sum  = {1'b0, cur_q} + {1'b0, STEP_V};
        dn_dif  = (cur_q > STEP_V) ? (cur_q - STEP_V) : '0;
        if (estop_i) begin
            cur_d  = '0;
            tgt_d  = '0;
            tdir_d = dir_q;
        end else begin
            if (tick_i) begin
                case (state_q)
                    HOLD: ;
                    RAMP_UP: cur_d = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[SPEED_W-1:0];
                    RAMP_DN: cur_d = (dn_dif <= tgt_q) ? tgt_q : dn_dif;
                    REVERSE: begin
                        // Direction only flips on a tick already sitting at 0.
                        if (cur_q == '0) dir_d = tdir_q;
                        else             cur_d = dn_dif;
                    end
                    default: ;
                endcase
            end
            if (load_i) begin
                tgt_d  = (ld_speed_i > SPD_MAX) ? SPD_MAX : ld_speed_i;
                tdir_d = ld_dir_i;
            end
        end
        state_d = estop_i ? HOLD : classify(cur_d, dir_d, tgt_d, tdir_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HOLD;
            cur_q   <= '0;
            dir_q   <= DIR_FWD;
            tgt_q   <= '0;
            tdir_q  <= DIR_FWD;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            tgt_q   <= tgt_d;
            tdir_q  <= tdir_d;
        end
    end

    assign speed_o  = cur_q;
    assign dir_o    = dir_q;
    assign active_o = (state_q != HOLD);

endmodule

// File: rtl/motor_cmd_ramp.sv
// Command stage for the two-channel PWM motor driver.
// Accepts left/right speed+direction targets over valid/ready and slews the
// applied values once per PWM period, passing through zero on reversal.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready = !rst && !estop)
//   cmd_speed_l/_dir_l/_r    target speed and direction per channel
//   estop                    level emergency stop
//   speed_l/dir_l/_r         applied speed/direction, stable over a period
//   period_start             one-cycle pulse while the period counter is 0
//   busy                     either channel still moving toward its target
module motor_cmd_ramp
    import motor_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int SPEED_W = SPEED_W_DEF,
    parameter int STEP    = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SPEED_W-1:0] cmd_speed_l,
    input  logic               cmd_dir_l,
    input  logic [SPEED_W-1:0] cmd_speed_r,
    input  logic               cmd_dir_r,
    input  logic               estop,
    output logic [SPEED_W-1:0] speed_l,
    output logic               dir_l,
    output logic [SPEED_W-1:0] speed_r,
    output logic               dir_r,
    output logic               period_start,
    output logic               busy
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             load;
    logic             period_start_q;
    logic             busy_q;
    logic             active_l, active_r;

    assign tick      = (cnt_q == CNT_W'(PERIOD - 1));
    assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
    assign cmd_ready = !rst && !estop;
    assign load      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= tick;
            busy_q         <= active_l | active_r;
        end
    end

    motor_ramp_ch #(
        .PERIOD (PERIOD),
        .SPEED_W(SPEED_W),
        .STEP   (STEP)
    ) u_ch_l (
        .clk_i     (clk),
        .rst_i     (rst),
        .tick_i    (tick),
        .load_i    (load),
        .estop_i   (estop),
        .ld_speed_i(cmd_speed_l),
        .ld_dir_i  (cmd_dir_l),
        .speed_o   (speed_l),
        .dir_o     (dir_l),
        .active_o  (active_l)
    );

    motor_ramp_ch #(
        .PERIOD (PERIOD),
        .SPEED_W(SPEED_W),
        .STEP   (STEP)
    ) u_ch_r (
        .clk_i     (clk),
        .rst_i     (rst),
        .tick_i    (tick),
        .load_i    (load),
        .estop_i   (estop),
        .ld_speed_i(cmd_speed_r),
        .ld_dir_i  (cmd_dir_r),
        .speed_o   (speed_r),
        .dir_o     (dir_r),
        .active_o  (active_r)
    );

    assign period_start = period_start_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp with PERIOD=20, STEP=5.
module tb_motor_cmd_ramp;

    localparam int P  = 20;
    localparam int SW = 14;
    localparam int ST = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_speed_l;
    logic          cmd_dir_l;
    logic [SW-1:0] cmd_speed_r;
    logic          cmd_dir_r;
    logic          estop;
    logic [SW-1:0] speed_l;
    logic          dir_l;
    logic [SW-1:0] speed_r;
    logic          dir_r;
    logic          period_start;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    motor_cmd_ramp #(
        .PERIOD (P),
        .SPEED_W(SW),
        .STEP   (ST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_speed_l (cmd_speed_l),
        .cmd_dir_l   (cmd_dir_l),
        .cmd_speed_r (cmd_speed_r),
        .cmd_dir_r   (cmd_dir_r),
        .estop       (estop),
        .speed_l     (speed_l),
        .dir_l       (dir_l),
        .speed_r     (speed_r),
        .dir_r       (dir_r),
        .period_start(period_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cmd;
        int csl;
        bit cdl;
        int csr;
        bit cdr;
        int esl;
        bit edl;
        int esr;
        bit edr;
        bit ebusy;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sl, input bit dl, input int sr, input bit dr);
        cmd_speed_l = SW'(sl);
        cmd_dir_l   = dl;
        cmd_speed_r = SW'(sr);
        cmd_dir_r   = dr;
        cmd_valid   = 1'b1;
        cycle();
        cmd_valid   = 1'b0;
    endtask

    // Advance to the next period_start, checking outputs hold still until then.
    task automatic wait_boundary();
        logic [SW-1:0] sl, sr;
        logic          dl, dr;
        bit            got, stable;
        sl = speed_l; sr = speed_r; dl = dir_l; dr = dir_r;
        got = 0; stable = 1;
        for (int i = 0; i < P + 5 && !got; i++) begin
            cycle();
            if (period_start) got = 1;
            else if (speed_l != sl || speed_r != sr || dir_l != dl || dir_r != dr) stable = 0;
        end
        chk("boundary_seen", int'(got), 1);
        chk("stable_in_period", int'(stable), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_sl;
        int prev_dl;
        int gap;

        tbl[0]  = '{1, 12, 1, 0, 1,   5, 1, 0, 1, 1};
        tbl[1]  = '{0,  0, 0, 0, 0,  10, 1, 0, 1, 1};
        tbl[2]  = '{0,  0, 0, 0, 0,  12, 1, 0, 1, 0};
        tbl[3]  = '{1, 10, 0, 0, 1,   7, 1, 0, 1, 1};
        tbl[4]  = '{0,  0, 0, 0, 0,   2, 1, 0, 1, 1};
        tbl[5]  = '{0,  0, 0, 0, 0,   0, 1, 0, 1, 1};
        tbl[6]  = '{0,  0, 0, 0, 0,   0, 0, 0, 1, 1};
        tbl[7]  = '{0,  0, 0, 0, 0,   5, 0, 0, 1, 1};
        tbl[8]  = '{0,  0, 0, 0, 0,  10, 0, 0, 1, 0};
        tbl[9]  = '{1, 10, 0, 30, 1, 10, 0, 5, 1, 1};
        tbl[10] = '{0,  0, 0, 0, 0,  10, 0, 10, 1, 1};
        tbl[11] = '{0,  0, 0, 0, 0,  10, 0, 15, 1, 1};
        tbl[12] = '{0,  0, 0, 0, 0,  10, 0, 20, 1, 0};
        tbl[13] = '{1, 10, 0, 3, 1,  10, 0, 15, 1, 1};
        tbl[14] = '{0,  0, 0, 0, 0,  10, 0, 10, 1, 1};
        tbl[15] = '{0,  0, 0, 0, 0,  10, 0, 5, 1, 1};
        tbl[16] = '{0,  0, 0, 0, 0,  10, 0, 3, 1, 0};
        tbl[17] = '{1, 10, 1, 3, 1,   5, 0, 3, 1, 1};
        tbl[18] = '{1, 20, 0, 3, 1,  10, 0, 3, 1, 1};
        tbl[19] = '{0,  0, 0, 0, 0,  15, 0, 3, 1, 1};
        tbl[20] = '{0,  0, 0, 0, 0,  20, 0, 3, 1, 0};

        rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0;
        cmd_speed_l = '0; cmd_dir_l = 1'b1; cmd_speed_r = '0; cmd_dir_r = 1'b1;

        // Reset values and idle period pulse spacing
        cycle();
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_speed_l", int'(speed_l), 0);
        chk("rst_dir_l", int'(dir_l), 1);
        chk("rst_speed_r", int'(speed_r), 0);
        chk("rst_dir_r", int'(dir_r), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_period_start", int'(period_start), 0);
        cycle();
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", int'(cmd_ready), 1);
        wait_boundary();
        gap = 0;
        for (int i = 1; i <= P + 5 && gap == 0; i++) begin
            cycle();
            if (i == 1) chk("pulse_width", int'(period_start), 0);
            if (period_start) gap = i;
        end
        chk("pulse_spacing", gap, P);
        chk("idle_busy", int'(busy), 0);
        cycle();
        cycle();

        // Table: one row per PWM period
        prev_sl = 0;
        prev_dl = 1;
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].cmd) send(tbl[i].csl, tbl[i].cdl, tbl[i].csr, tbl[i].cdr);
            wait_boundary();
            cycle();
            cycle();
            chk($sformatf("v%0d_speed_l", i), int'(speed_l), tbl[i].esl);
            chk($sformatf("v%0d_dir_l", i), int'(dir_l), int'(tbl[i].edl));
            chk($sformatf("v%0d_speed_r", i), int'(speed_r), tbl[i].esr);
            chk($sformatf("v%0d_dir_r", i), int'(dir_r), int'(tbl[i].edr));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].ebusy));
            if (int'(dir_l) != prev_dl)
                chk($sformatf("v%0d_rev_at_zero", i), int'(speed_l == '0 && prev_sl == 0), 1);
            prev_sl = int'(speed_l);
            prev_dl = int'(dir_l);
        end

        // Command landing on the tick cycle only moves output a period later
        wait_boundary();
        repeat (P - 1) @(posedge clk);
        #1;
        cmd_speed_l = SW'(5); cmd_dir_l = 1'b0;
        cmd_speed_r = SW'(3); cmd_dir_r = 1'b1;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        chk("coll_boundary", int'(period_start), 1);
        chk("coll_old_target", int'(speed_l), 20);
        wait_boundary();
        chk("coll_new_target", int'(speed_l), 15);
        wait_boundary();
        chk("pre_estop_speed_l", int'(speed_l), 10);

        // estop mid-ramp, with a command offered that must be ignored
        cycle();
        cycle();
        estop = 1'b1;
        cmd_speed_l = SW'(20); cmd_dir_l = 1'b1;
        cmd_speed_r = SW'(20); cmd_dir_r = 1'b1;
        cmd_valid = 1'b1;
        #1;
        chk("estop_cmd_ready", int'(cmd_ready), 0);
        cycle();
        chk("estop_speed_l", int'(speed_l), 0);
        chk("estop_speed_r", int'(speed_r), 0);
        chk("estop_dir_l", int'(dir_l), 0);
        chk("estop_dir_r", int'(dir_r), 1);
        cycle();
        cycle();
        estop = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("post_estop_cmd_ready", int'(cmd_ready), 1);
        wait_boundary();
        wait_boundary();
        cycle();
        cycle();
        chk("post_estop_speed_l", int'(speed_l), 0);
        chk("post_estop_speed_r", int'(speed_r), 0);
        chk("post_estop_dir_l", int'(dir_l), 0);
        chk("post_estop_busy", int'(busy), 0);

        // Reset while a reversal is in progress
        send(15, 1'b0, 0, 1'b1);
        wait_boundary();
        wait_boundary();
        wait_boundary();
        chk("pre_rev_speed_l", int'(speed_l), 15);
        cycle();
        send(15, 1'b1, 0, 1'b1);
        wait_boundary();
        cycle();
        cycle();
        chk("rev_speed_l", int'(speed_l), 10);
        chk("rev_dir_l", int'(dir_l), 0);
        chk("rev_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
        cycle();
        chk("mid_rst_speed_l", int'(speed_l), 0);
        chk("mid_rst_dir_l", int'(dir_l), 1);
        chk("mid_rst_speed_r", int'(speed_r), 0);
        chk("mid_rst_dir_r", int'(dir_r), 1);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        wait_boundary();
        cycle();
        cycle();
        chk("after_rst_speed_l", int'(speed_l), 0);
        chk("after_rst_dir_l", int'(dir_l), 1);
        chk("after_rst_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
